// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized, oversampled, 8N1 framing with one-cycle valid/error strobes.
// Optional even parity bit (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 tx_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W  = 3;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t               state_q, state_d;
  logic [1:0]           rx_sync_q;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;
  logic                 tick_last;
  logic                 tick_half;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d;
  logic                 perr_q, perr_d;
`endif

  assign rx_s      = rx_sync_q[1];
  assign tick_last = (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign tick_half = (tick_q == TICK_W'(OVERSAMPLE / 2 - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        tick_d = '0;
        idx_d  = '0;
        if (en && !rx_s) state_d = START;
      end
      START: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_half) begin
          tick_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_last) begin
          tick_d         = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_last) begin
          tick_d  = '0;
          pbad_d  = ^{shift_q, rx_s};
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_last) begin
          tick_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = pbad_q;
`endif
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line returns high so a break is not seen as new starts
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_sync_q <= 2'b11;
      tick_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_sync_q <= {rx_sync_q[0], rx_in};
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= pbad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued when driven and checked when the DUT strobes.
module tb_uart_rx;

  localparam int unsigned OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int LAT_NOM = 2 + OS / 2 + (FRAME_BITS - 1) * OS;

  logic       tx_clk, rst, en, rx_in;
  logic [7:0] data_out;
  logic       data_valid, busy, frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   dv_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [7:0] last_good = 8'h00;
  logic prev_evt = 1'b0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .tx_clk     (tx_clk),
    .rst        (rst),
    .en         (en),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_err  (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;
  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pops one expectation per DUT strobe and checks payload, exclusivity, width and latency
  always @(negedge tx_clk) begin
    if (data_valid || frame_err) begin
      exp_t e;
      chk("dv_fe_exclusive", 32'(data_valid & frame_err), 32'd0);
      chk("strobe_one_cycle", 32'(prev_evt), 32'd0);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("frame_err", 32'(frame_err), 32'(e.ferr));
        chk("data_valid", 32'(data_valid), 32'(!e.ferr));
        chk("data_out", 32'(data_out), 32'(e.data));
`ifdef UART_RX_PARITY_EN
        chk("parity_err", 32'(parity_err), 32'(e.perr));
`endif
        if (!e.ferr) begin
          int lat;
          lat = cyc - e.start;
          chk("latency_window", 32'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 32'd1);
          dv_cyc.push_back(cyc);
        end
      end
    end
    prev_evt = data_valid || frame_err;
  end

  task automatic hold_bit(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge tx_clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v, input logic par_v);
    exp_t e;
    e.ferr  = !stop_v;
    e.data  = stop_v ? b : last_good;
    e.perr  = stop_v && ((^b) ^ par_v);
    e.start = cyc;
    sb.push_back(e);
    if (stop_v) last_good = b;
    hold_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) hold_bit(b[i], OS);
`ifdef UART_RX_PARITY_EN
    hold_bit(par_v, OS);
`endif
    hold_bit(stop_v, OS);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge tx_clk);
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rx_in = 1'b1;
    repeat (3) @(negedge tx_clk);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge tx_clk);

    send(8'hA5, 1'b1, ^8'hA5);
    wait_drain("drain_a5");
    repeat (4) @(negedge tx_clk);
    chk("busy_after_a5", 32'(busy), 32'd0);

    hold_bit(1'b0, 4);
    hold_bit(1'b1, 3);
    chk("glitch_busy_high", 32'(busy), 32'd1);
    repeat (20) @(negedge tx_clk);
    chk("glitch_busy_low", 32'(busy), 32'd0);
    send(8'h3C, 1'b1, ^8'h3C);
    wait_drain("drain_3c");

    send(8'h5A, 1'b0, ^8'h5A);
    hold_bit(1'b0, 40 - OS);
    chk("wait_high_busy", 32'(busy), 32'd1);
    wait_drain("drain_5a_ferr");
    hold_bit(1'b1, 5);
    chk("wait_high_exit", 32'(busy), 32'd0);
    send(8'h81, 1'b1, ^8'h81);
    wait_drain("drain_81");
    repeat (10) @(negedge tx_clk);

    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    wait_drain("drain_b2b");
    if (dv_cyc.size() >= 2)
      chk("b2b_gap", 32'(dv_cyc[dv_cyc.size()-1] - dv_cyc[dv_cyc.size()-2]), 32'(FRAME_BITS * OS));
    else
      chk("b2b_count", 32'(dv_cyc.size()), 32'd2);
    repeat (10) @(negedge tx_clk);

    hold_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) hold_bit(1'(8'h77 >> i), OS);
    rst = 1'b1;
    hold_bit(1'b1, 3);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dv", 32'(data_valid), 32'd0);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (5) @(negedge tx_clk);
    send(8'h12, 1'b1, ^8'h12);
    wait_drain("drain_12");

`ifdef UART_RX_PARITY_EN
    repeat (10) @(negedge tx_clk);
    send(8'h07, 1'b1, 1'b1);
    wait_drain("drain_par_ok");
    repeat (10) @(negedge tx_clk);
    send(8'h07, 1'b1, 1'b0);
    wait_drain("drain_par_bad");
`endif

    repeat (OS * 4) @(negedge tx_clk);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    chk("idle_end", 32'(busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
